signed_seq_multiplier: RTL and testbench

SIGNED_SEQ_MULTIPLIER -- requirements
Module: signed_seq_multiplier

---
 rtl/signed_seq_multiplier_if.sv | 26 ++
 rtl/signed_seq_multiplier.sv | 163 ++++++++++++++++
 tb/tb_signed_seq_multiplier.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/signed_seq_multiplier_if.sv
// Handshake and operand bundle for signed_seq_multiplier.
// master: the requester driving operands and Start.
// slave:  the multiplier returning Busy, Done and Result.
interface signed_seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               Start;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               s0;
  logic               s1;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH:0]   Result;

  modport master (
    output Start, sel, A, B, s0, s1,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, sel, A, B, s0, s1,
    output Busy, Done, Result
  );
endinterface

// File: rtl/signed_seq_multiplier.sv
// Sequential sign-magnitude multiplier (shift-and-add, one step per cycle).
// Operands arrive as unsigned magnitudes plus separate sign bits. The product
// is returned as {sign, magnitude[2*WIDTH-1:0]}; a zero product is never negative.
// FSM: IDLE -> CALC (WIDTH steps) -> DONE (one cycle, Done pulse) -> IDLE.
// Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining multiplier
// bits are all zero (at least one CALC step is always taken).
module signed_seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  signed_seq_multiplier_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    accept_s;
  logic                    last_step_s;

  logic [2*WIDTH-1:0]      mcand_r;
  logic [WIDTH-1:0]        mplier_r;
  logic [2*WIDTH-1:0]      acc_r;
  logic [CW-1:0]           cnt_r;
  logic                    s0_r;
  logic                    s1_r;
  logic                    busy_r;
  logic                    done_r;
  logic [2*WIDTH:0]        result_r;

  // Pack magnitude with its sign; a zero magnitude always carries sign 0.
  function automatic logic [2*WIDTH:0] pack_result(
    input logic               sign_a,
    input logic               sign_b,
    input logic [2*WIDTH-1:0] mag
  );
    logic sign_v;
    sign_v = (sign_a ^ sign_b) & (|mag);
    return {sign_v, mag};
  endfunction

  // State register; Reset wins over any request in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode, accept qualification and CALC exit condition.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_step_s  = 1'b0;
`ifdef EARLY_TERM_EN
    if ((cnt_r == LAST_CNT) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
`else
    if (cnt_r == LAST_CNT) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.Start && (bus.sel == 2'b01)) begin
          accept_s     = 1'b1;
          next_state_s = ST_CALC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (last_step_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand latch, shift-and-add step, and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      s0_r     <= 1'b0;
      s1_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {(2*WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, bus.A};
            mplier_r <= bus.B;
            s0_r     <= bus.s0;
            s1_r     <= bus.s1;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_CALC: begin
          done_r <= 1'b0;
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CW'(1);
          if (last_step_s) begin
            busy_r <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          result_r <= pack_result(s0_r, s1_r, acc_r);
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.Result = result_r;

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed self-checking bench for signed_seq_multiplier (WIDTH=4).
// Latency expectations follow EARLY_TERM_EN when the bench is built with it.
module tb_signed_seq_multiplier;

  localparam int W = 4;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  signed_seq_multiplier_if #(.WIDTH(W)) bus ();

  signed_seq_multiplier #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one multiply, then observe latency (edges after the accept edge
  // until Done is seen), Busy-high samples and Result. lat=0 means timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb,
                        output int lat, output int busy_cyc,
                        output logic [2*W:0] res);
    bus.A = a; bus.B = b; bus.s0 = sa; bus.s1 = sb;
    bus.sel = 2'b01; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    lat = 0;
    busy_cyc = (bus.Busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.Busy === 1'b1) busy_cyc++;
      if (bus.Done === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = bus.Result;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.sel = 2'b00; bus.A = '0; bus.B = '0;
    bus.s0 = 1'b0; bus.s1 = 1'b0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_checks++;
    if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.Done); end
    n_checks++;
    if (bus.Result !== 9'h000) begin n_fail++; $display("FAIL reset_result got %h want 000", bus.Result); end
  endtask

  task automatic test_multiply();
    int lat, bc;
    logic [2*W:0] res;
    int exp_lat[4];
    logic [3:0] av[4] = '{4'd3, 4'd7, 4'd0, 4'd15};
    logic [3:0] bv[4] = '{4'd5, 4'd6, 4'd9, 4'd15};
    logic       sav[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       sbv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] ev[4] = '{9'h00F, 9'h12A, 9'h000, 9'h0E1};
`ifdef EARLY_TERM_EN
    exp_lat = '{4, 4, 5, 5};
`else
    exp_lat = '{5, 5, 5, 5};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], sav[i], sbv[i], lat, bc, res);
      n_checks++;
      if (res !== ev[i]) begin n_fail++; $display("FAIL mul_result[%0d] got %h want %h", i, res, ev[i]); end
      n_checks++;
      if (lat != exp_lat[i]) begin n_fail++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, exp_lat[i]); end
      n_checks++;
      if (bc != exp_lat[i] - 1) begin n_fail++; $display("FAIL mul_busy[%0d] got %0d want %0d", i, bc, exp_lat[i] - 1); end
      tick();
    end
  endtask

  task automatic test_ignore();
    int dones;
    // Wrong mode in IDLE: nothing starts, previous Result (0x0E1) stays.
    bus.A = 4'd2; bus.B = 4'd2; bus.s0 = 1'b0; bus.s1 = 1'b0;
    bus.sel = 2'b10; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL ign_sel_busy got %b want 0", bus.Busy); end
    dones = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.Done === 1'b1) dones++; end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL ign_sel_done got %0d want 0", dones); end
    n_checks++;
    if (bus.Result !== 9'h0E1) begin n_fail++; $display("FAIL ign_sel_result got %h want 0e1", bus.Result); end
    // Start 3*5, then a new Start with new operands during CALC.
    bus.A = 4'd3; bus.B = 4'd5; bus.s0 = 1'b0; bus.s1 = 1'b0;
    bus.sel = 2'b01; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    bus.A = 4'd15; bus.B = 4'd15; bus.s0 = 1'b1; bus.s1 = 1'b0; bus.Start = 1'b1;
    tick(); tick();
    bus.Start = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (bus.Done === 1'b1) dones++; end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL ign_calc_dones got %0d want 1", dones); end
    n_checks++;
    if (bus.Result !== 9'h00F) begin n_fail++; $display("FAIL ign_calc_result got %h want 00f", bus.Result); end
  endtask

  task automatic test_reset_mid();
    int dones, lat, bc;
    logic [2*W:0] res;
    bus.A = 4'd7; bus.B = 4'd6; bus.s0 = 1'b1; bus.s1 = 1'b0;
    bus.sel = 2'b01; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.Busy); end
    n_checks++;
    if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", bus.Done); end
    n_checks++;
    if (bus.Result !== 9'h000) begin n_fail++; $display("FAIL mid_result got %h want 000", bus.Result); end
    dones = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.Done === 1'b1) dones++; end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL mid_nodone got %0d want 0", dones); end
    run_op(4'd3, 4'd5, 1'b0, 1'b0, lat, bc, res);
    n_checks++;
    if (res !== 9'h00F) begin n_fail++; $display("FAIL mid_after_result got %h want 00f", res); end
  endtask

  task automatic test_reset_priority();
    int dones;
    bus.A = 4'd5; bus.B = 4'd5; bus.s0 = 1'b0; bus.s1 = 1'b0;
    bus.sel = 2'b01; bus.Start = 1'b1; Reset = 1'b1;
    tick();
    bus.Start = 1'b0; Reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy got %b want 0", bus.Busy); end
    dones = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (bus.Done === 1'b1) dones++; end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL prio_nodone got %0d want 0", dones); end
    n_checks++;
    if (bus.Result !== 9'h000) begin n_fail++; $display("FAIL prio_result got %h want 000", bus.Result); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, exp_l;
    logic [2*W:0] res;
`ifdef EARLY_TERM_EN
    exp_l = 4;
`else
    exp_l = 5;
`endif
    run_op(4'd3, 4'd5, 1'b0, 1'b0, lat, bc, res);
    // Issued while Done is high: sampled next edge with the FSM in IDLE.
    run_op(4'd7, 4'd6, 1'b1, 1'b0, lat, bc, res);
    n_checks++;
    if (res !== 9'h12A) begin n_fail++; $display("FAIL b2b_result got %h want 12a", res); end
    n_checks++;
    if (lat != exp_l) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, exp_l); end
    tick();
    n_checks++;
    if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse got %b want 0", bus.Done); end
  endtask

  task automatic test_early_term();
    int lat, bc, exp_l;
    logic [2*W:0] res;
`ifdef EARLY_TERM_EN
    exp_l = 2;
`else
    exp_l = 5;
`endif
    run_op(4'd9, 4'd1, 1'b0, 1'b0, lat, bc, res);
    n_checks++;
    if (res !== 9'h009) begin n_fail++; $display("FAIL et_b1_result got %h want 009", res); end
    n_checks++;
    if (lat != exp_l) begin n_fail++; $display("FAIL et_b1_latency got %0d want %0d", lat, exp_l); end
    tick();
    run_op(4'd9, 4'd0, 1'b1, 1'b0, lat, bc, res);
    n_checks++;
    if (res !== 9'h000) begin n_fail++; $display("FAIL et_b0_result got %h want 000", res); end
    n_checks++;
    if (lat != exp_l) begin n_fail++; $display("FAIL et_b0_latency got %0d want %0d", lat, exp_l); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    test_reset();
    test_multiply();
    test_ignore();
    test_reset_mid();
    test_reset_priority();
    test_back_to_back();
    test_early_term();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
